// File: rtl/div_share_ctrl.sv
// Two-requester sequencing/arbitration controller for a shared iterative divider.
// Round-robin grant, one-cycle divider start, per-requester response buffers,
// flush handling, and optional in-controller resolution of divide-by-zero and
// signed overflow.
module div_share_ctrl #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int FAST_PATH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             flush0,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush1,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             div_start,
  output logic [1:0]       div_opcode,
  output logic [XLEN-1:0]  div_operand1,
  output logic [XLEN-1:0]  div_operand2,
  input  logic             div_done,
  input  logic [XLEN-1:0]  div_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ZERO_V = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_V = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};

  // True when the op can be answered without running the divider.
  function automatic logic is_fast(input logic [1:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    logic r;
    if (FAST_PATH != 0) begin
      r = (b == ZERO_V) || (op[1] && (a == MIN_V) && (b == ONES_V));
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  // Architectural result for divide-by-zero and signed overflow.
  function automatic logic [XLEN-1:0] fast_result(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    if (b == ZERO_V) begin
      r = op[0] ? a : ONES_V;
    end else begin
      r = op[0] ? ZERO_V : MIN_V;
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              rr_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, res_q;
  logic              owner_q, fast_q, kill_q;
  logic              div_start_q, div_start_d;
  logic              busy_q, busy_d;
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [XLEN-1:0]   rsp0_data_q, rsp1_data_q;
  logic [TAG_W-1:0]  rsp0_tag_q, rsp1_tag_q, tag_q;

  logic              elig0_s, elig1_s, gnt0_s, gnt1_s, acc_s;
  logic [1:0]        sel_op_s;
  logic [XLEN-1:0]   sel_a_s, sel_b_s, sel_res_s;
  logic [TAG_W-1:0]  sel_tag_s;
  logic              sel_fast_s;
  logic              wr_s, wr0_s, wr1_s, owner_flush_s;
  logic [XLEN-1:0]   wr_data_s;

  // Eligibility and round-robin grant; only one requester can win per cycle.
  always_comb begin
    elig0_s = 1'b0;
    elig1_s = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      elig0_s = req0_valid && !rsp0_valid_q && !flush0;
      elig1_s = req1_valid && !rsp1_valid_q && !flush1;
    end else begin
      elig0_s = 1'b0;
      elig1_s = 1'b0;
    end
    gnt0_s = elig0_s && (!elig1_s || !rr_q);
    gnt1_s = elig1_s && (!elig0_s || rr_q);
    acc_s  = gnt0_s || gnt1_s;
  end

  // Mux the granted request and pre-compute its fast-path classification.
  always_comb begin
    sel_op_s  = req0_op;
    sel_a_s   = req0_a;
    sel_b_s   = req0_b;
    sel_tag_s = req0_tag;
    if (gnt1_s) begin
      sel_op_s  = req1_op;
      sel_a_s   = req1_a;
      sel_b_s   = req1_b;
      sel_tag_s = req1_tag;
    end else begin
      sel_op_s  = req0_op;
      sel_a_s   = req0_a;
      sel_b_s   = req0_b;
      sel_tag_s = req0_tag;
    end
    sel_fast_s = is_fast(sel_op_s, sel_a_s, sel_b_s);
    sel_res_s  = fast_result(sel_op_s, sel_a_s, sel_b_s);
  end

  // Result write: fast results leave from RESP, divider results the edge done is seen.
  always_comb begin
    wr_s          = ((state_q == RESP) && fast_q) || ((state_q == WAIT) && div_done);
    wr_data_s     = fast_q ? res_q : div_result;
    owner_flush_s = owner_q ? flush1 : flush0;
    wr0_s         = wr_s && !owner_q && !kill_q;
    wr1_s         = wr_s && owner_q && !kill_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; div_done is only looked at in WAIT so a stale done is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc_s) begin
          state_d = sel_fast_s ? RESP : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    div_start_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  // Registered FSM outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_start_q <= div_start_d;
      busy_q      <= busy_d;
    end
  end

  // Latch the accepted op, advance the round-robin pointer, track kills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= ZERO_V;
      b_q     <= ZERO_V;
      res_q   <= ZERO_V;
      tag_q   <= {TAG_W{1'b0}};
      owner_q <= 1'b0;
      fast_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else if (acc_s) begin
      rr_q    <= gnt0_s;
      op_q    <= sel_op_s;
      a_q     <= sel_a_s;
      b_q     <= sel_b_s;
      res_q   <= sel_res_s;
      tag_q   <= sel_tag_s;
      owner_q <= gnt1_s;
      fast_q  <= sel_fast_s;
      kill_q  <= 1'b0;
    end else if ((state_q != IDLE) && owner_flush_s) begin
      kill_q  <= 1'b1;
    end else begin
      kill_q  <= kill_q;
    end
  end

  // Requester 0 response buffer; flush wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= ZERO_V;
      rsp0_tag_q   <= {TAG_W{1'b0}};
    end else if (flush0) begin
      rsp0_valid_q <= 1'b0;
    end else if (wr0_s) begin
      rsp0_valid_q <= 1'b1;
      rsp0_data_q  <= wr_data_s;
      rsp0_tag_q   <= tag_q;
    end else if (rsp0_valid_q && rsp0_ready) begin
      rsp0_valid_q <= 1'b0;
    end else begin
      rsp0_valid_q <= rsp0_valid_q;
    end
  end

  // Requester 1 response buffer; flush wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= ZERO_V;
      rsp1_tag_q   <= {TAG_W{1'b0}};
    end else if (flush1) begin
      rsp1_valid_q <= 1'b0;
    end else if (wr1_s) begin
      rsp1_valid_q <= 1'b1;
      rsp1_data_q  <= wr_data_s;
      rsp1_tag_q   <= tag_q;
    end else if (rsp1_valid_q && rsp1_ready) begin
      rsp1_valid_q <= 1'b0;
    end else begin
      rsp1_valid_q <= rsp1_valid_q;
    end
  end

  assign req0_ready   = gnt0_s;
  assign req1_ready   = gnt1_s;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_data    = rsp0_data_q;
  assign rsp0_tag     = rsp0_tag_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_data    = rsp1_data_q;
  assign rsp1_tag     = rsp1_tag_q;
  assign div_start    = div_start_q;
  assign div_opcode   = op_q;
  assign div_operand1 = a_q;
  assign div_operand2 = b_q;
  assign busy         = busy_q;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Sequencing and arbitration controller for the shared iterative 32-bit divide unit of the M-extension. Two requesters (N=0: EX-stage M-unit, N=1: secondary/debug port) issue DIV/DIVU/REM/REMU with valid/ready handshakes. The block round-robins between them, pulses the divider start, and waits for done. It resolves divide-by-zero and signed overflow itself without using the divider. Results are held per requester until accepted, and flushed requests are discarded.

Parameters:
XLEN, 32, operand/result width
TAG_W, 5, width of requester tag (e.g. rd index) carried to response
FAST_PATH, 1, 1 = resolve div-by-zero/overflow in controller; 0 = always use divider

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
reqN_valid  in  1  request valid (N=0,1)
reqN_ready  out  1  request accepted when valid&&ready
reqN_op  in  2  op[1]=signed, op[0]=remainder: 00 DIVU, 01 REMU, 10 DIV, 11 REM
reqN_a  in  XLEN  dividend
reqN_b  in  XLEN  divisor
reqN_tag  in  TAG_W  opaque tag
flushN  in  1  kill requester N's outstanding/pending op
rspN_valid  out  1  result valid, held until rspN_ready
rspN_ready  in  1  result consumed
rspN_data  out  XLEN  quotient/remainder
rspN_tag  out  TAG_W  tag of the op
div_start  out  1  one-cycle start pulse to divider
div_opcode  out  2  op to divider (reqN_op unchanged)
div_operand1  out  XLEN  dividend to divider (registered)
div_operand2  out  XLEN  divisor to divider (registered)
div_done  in  1  divider done (level; cleared by divider on start)
div_result  in  XLEN  divider result, valid while div_done=1
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, all outputs 0, rr_ptr=0 (requester 0 has priority first), response buffers empty. rst mid-operation aborts everything; the divider is reset by the same rst.
- States: IDLE, ISSUE, WAIT, RESP.
- reqN_ready=1 only in IDLE, when requester N's response buffer is empty, flushN=0, and N wins arbitration. At most one ready per cycle.
- Arbitration: if both are eligible, grant rr_ptr. After each grant rr_ptr = ~granted.
- On accept (IDLE edge): latch op/a/b/tag/owner.
  - Fast path (FAST_PATH=1) when b==0, or signed op with a==0x80000000 && b==0xFFFFFFFF. Result: DIV/DIVU by 0 -> 0xFFFFFFFF; REM/REMU by 0 -> a; DIV overflow -> 0x80000000; REM overflow -> 0. Go to RESP. div_start is never pulsed.
  - Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle with registered operands. Next state is WAIT.
- WAIT: div_done is sampled only here. div_done is never sampled in the ISSUE cycle, because a stale done from the previous op may still be high. On div_done=1, capture div_result and go to RESP.
- RESP: write the result/tag into owner's response buffer, unless the owner was flushed since accept (kill flag); then go to IDLE. Latency: fast path rspN_valid 2 cycles after accept edge. Divider path: rspN_valid 1 cycle after div_done is seen in WAIT.
- Response buffer: one entry per requester. rspN_valid stays high with data stable until rspN_ready. It is cleared on the edge where rspN_valid&&rspN_ready.
- flushN: clears N's response buffer (valid->0) and sets kill if N owns the in-flight op. The divider run is not aborted; its result is dropped. flushN on the same edge as rspN_valid&&rspN_ready: the buffer clears, with no error.
- The other requester can be granted once the state returns to IDLE, even while the killed op's result is discarded.
- Operands b==0 with FAST_PATH=0: forwarded to the divider; its result is returned unmodified.

Test Plan:
- req0 DIVU a=100 b=7 -> one div_start pulse, rsp0_data=14 after div_done. Then REMU same operands -> 2. Tags echoed.
- req1 DIV a=0x80000000 b=0xFFFFFFFF, and REM same -> rsp1_data 0x80000000 / 0, each 2 cycles after accept, div_start never asserted. REMU a=5 b=0 -> 5. DIVU a=5 b=0 -> 0xFFFFFFFF.
- req0 and req1 both valid continuously, rr_ptr=0 -> grants alternate 0,1,0,1. Each result goes to the correct rspN with the correct tag. No double start.
- rsp0_ready held low for 50 cycles after a result -> rsp0_valid/data stable, req0_ready=0, req1 still served.
- flush0 asserted during WAIT of req0 DIV a=-20 b=3 -> rsp0_valid never rises, busy falls after div_done, next req1 op REM a=-20 b=3 -> -2.
- rst asserted mid-WAIT -> all outputs 0 on the same cycle. After release, a new DIVU 9/3 -> 3.
